// File: rtl/sap_mar_ram.sv
// sap_mar_ram -- memory address register plus read/write RAM for a SAP-class CPU.
//
// The MAR and RAM share one tri-state data bus with the rest of the datapath.
// The array can be written from the bus. It can also be bulk-loaded through a
// ready/valid programming port, which starts at address 0 and fills upward.
//
// Optional feature macro: SAP_MAR_RAM_BOOT_EN
//   When defined, the array powers up holding the demo program
//   (LDA 13 / OUT / ADD 14 / OUT / SUB 15 / OUT / HALT; data 8,5,4 at 13..15).
//   The preload assumes DATA_WIDTH=8 and ADDR_WIDTH>=4.
//   When undefined, every word powers up as 0.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            synchronous active-high reset (RAM contents are kept)
//   enable_input   load MAR from data_bus[ADDR_WIDTH-1:0]
//   enable_output  drive ram[MAR] onto data_bus (combinational read)
//   enable_write   write data_bus into ram[MAR] (ignored while enable_output)
//   increment      MAR <= MAR + 1, wrapping; enable_input takes priority
//   data_bus       shared tri-state bus
//   prog_mode      level request for programming mode
//   prog_data      programming word
//   prog_valid     prog_data valid
//   prog_ready     programming word is accepted this cycle
//   prog_done      the whole array has been programmed
//   addr           current MAR value
module sap_mar_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_input,
  input  logic                  enable_output,
  input  logic                  enable_write,
  input  logic                  increment,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  input  logic                  prog_mode,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_valid,
  output logic                  prog_ready,
  output logic                  prog_done,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {RUN, PROG, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] mar;
  logic [ADDR_WIDTH-1:0] ptr;

  // Power-up contents come from the declaration. Reset never touches the array.
`ifdef SAP_MAR_RAM_BOOT_EN
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{
    0:  DATA_WIDTH'(8'h1D),
    1:  DATA_WIDTH'(8'h40),
    2:  DATA_WIDTH'(8'h2E),
    3:  DATA_WIDTH'(8'h40),
    4:  DATA_WIDTH'(8'h3F),
    5:  DATA_WIDTH'(8'h40),
    6:  DATA_WIDTH'(8'hF0),
    13: DATA_WIDTH'(8'h08),
    14: DATA_WIDTH'(8'h05),
    15: DATA_WIDTH'(8'h04),
    default: '0
  };
`else
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
`endif

  assign addr = mar;

  // The read is combinational, so the new MAR is visible on the bus in the
  // cycle right after the load edge.
  assign data_bus = (state == RUN && enable_output) ? mem[mar] : {DATA_WIDTH{1'bz}};

  // Array writes. A bus write uses the pre-edge MAR, so a write combined with a
  // load lands at the old address. While enable_output is high, the bus carries
  // our own read data, so the write is dropped. On a reset edge, the in-flight
  // programming word is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RUN && enable_write && !enable_output)
        mem[mar] <= data_bus;
      else if (state == PROG && prog_valid)
        mem[ptr] <= prog_data;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      mar        <= '0;
      ptr        <= '0;
      prog_ready <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // With enable_output also high, this loads the MAR's own read data
          // (indirect addressing).
          if (enable_input)
            mar <= data_bus[ADDR_WIDTH-1:0];
          else if (increment)
            mar <= mar + ADDR_WIDTH'(1);
          if (prog_mode) begin
            state      <= PROG;
            ptr        <= '0;
            prog_ready <= 1'b1;
          end
        end
        PROG: begin
          // prog_ready is high throughout PROG, so any valid word is accepted.
          // That includes the word on the edge where prog_mode drops.
          if (prog_valid)
            ptr <= ptr + ADDR_WIDTH'(1);
          if (prog_valid && ptr == {ADDR_WIDTH{1'b1}}) begin
            // The last word was accepted, so the pointer never needs to wrap.
            state      <= DONE;
            prog_ready <= 1'b0;
            prog_done  <= 1'b1;
          end else if (!prog_mode) begin
            // Abort: words not yet written keep their old contents.
            state      <= RUN;
            prog_ready <= 1'b0;
            mar        <= '0;
          end
        end
        DONE: begin
          if (!prog_mode) begin
            state     <= RUN;
            prog_done <= 1'b0;
            mar       <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
